// File: rtl/jt12_phase_gen.sv
// Phase generator for 24 FM slots: per-slot increment from fnum/block/mul, 20-bit accumulators.
// Optional detune is enabled by defining JT12_PG_DT_EN.
module jt12_phase_gen #(
    parameter int PHASE_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        wr_en,
    input  logic [4:0]  wr_slot,
    input  logic [10:0] wr_fnum,
    input  logic [2:0]  wr_block,
    input  logic [3:0]  wr_mul,
    input  logic [2:0]  wr_dt,
    input  logic        kon,
    input  logic [4:0]  kon_slot,
    output logic [9:0]  pg_phase,
    output logic [4:0]  pg_slot,
    output logic        pg_valid,
    output logic        slot_sync
);

    logic [10:0]        fnum_r  [24];
    logic [2:0]         block_r [24];
    logic [3:0]         mul_r   [24];
`ifdef JT12_PG_DT_EN
    logic [2:0]         dt_r    [24];
    logic [2:0]         dt_s;
    logic [17:0]        dt_off_s;
`else
    logic               unused_dt_s;
`endif
    logic [PHASE_W-1:0] acc_r   [24];
    logic [23:0]        pend_r;

    logic [4:0]         slot_r;
    logic [19:0]        s1_inc_r;
    logic [4:0]         s1_slot_r;
    logic               s1_valid_r;

    logic [10:0]        fnum_s;
    logic [2:0]         block_s;
    logic [3:0]         mul_s;
    logic [17:0]        shifted_s;
    logic [16:0]        inc_base_s;
    logic [17:0]        base_s;
    logic [21:0]        prod_s;
    logic [19:0]        inc_s;
    logic [PHASE_W-1:0] acc_sum_s;
    logic [PHASE_W-1:0] acc_new_s;
    logic               pend_hit_s;

`ifndef JT12_PG_DT_EN
    assign unused_dt_s = ^wr_dt;
`endif

    // Stage 1: increment for the slot currently visited, from its stored config
    always_comb begin
        fnum_s     = fnum_r[slot_r];
        block_s    = block_r[slot_r];
        mul_s      = mul_r[slot_r];
        shifted_s  = {7'd0, fnum_s} << block_s;
        inc_base_s = shifted_s[17:1];
`ifdef JT12_PG_DT_EN
        dt_s     = dt_r[slot_r];
        dt_off_s = {16'd0, dt_s[1:0]} << block_s;
        if (dt_s[2]) begin
            if ({1'b0, inc_base_s} > dt_off_s) begin
                base_s = {1'b0, inc_base_s} - dt_off_s;
            end else begin
                base_s = 18'd0;
            end
        end else begin
            base_s = {1'b0, inc_base_s} + dt_off_s;
        end
`else
        base_s = {1'b0, inc_base_s};
`endif
        prod_s = {4'd0, base_s} * {18'd0, mul_s};
        if (mul_s == 4'd0) begin
            inc_s = {3'd0, base_s[17:1]};
        end else begin
            inc_s = prod_s[19:0];
        end
    end

    // Stage 2: accumulate, or restart from zero when a key-on is pending
    always_comb begin
        pend_hit_s = pend_r[s1_slot_r];
        acc_sum_s  = acc_r[s1_slot_r] + s1_inc_r;
        if (pend_hit_s) begin
            acc_new_s = '0;
        end else begin
            acc_new_s = acc_sum_s;
        end
    end

    // Per-slot configuration storage; writes land regardless of cen
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 24; i++) begin
                fnum_r[i]  <= 11'd0;
                block_r[i] <= 3'd0;
                mul_r[i]   <= 4'd0;
`ifdef JT12_PG_DT_EN
                dt_r[i]    <= 3'd0;
`endif
            end
        end else if (wr_en && (wr_slot < 5'd24)) begin
            fnum_r[wr_slot]  <= wr_fnum;
            block_r[wr_slot] <= wr_block;
            mul_r[wr_slot]   <= wr_mul;
`ifdef JT12_PG_DT_EN
            dt_r[wr_slot]    <= wr_dt;
`endif
        end
    end

    // Slot sequencing, two-stage pipeline, accumulators, key-on pending bits and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r     <= 5'd0;
            s1_inc_r   <= 20'd0;
            s1_slot_r  <= 5'd0;
            s1_valid_r <= 1'b0;
            pend_r     <= 24'd0;
            pg_phase   <= 10'd0;
            pg_slot    <= 5'd0;
            pg_valid   <= 1'b0;
            slot_sync  <= 1'b0;
            for (int i = 0; i < 24; i++) begin
                acc_r[i] <= '0;
            end
        end else begin
            if (cen) begin
                slot_r     <= (slot_r == 5'd23) ? 5'd0 : slot_r + 5'd1;
                s1_inc_r   <= inc_s;
                s1_slot_r  <= slot_r;
                s1_valid_r <= 1'b1;
                if (s1_valid_r) begin
                    acc_r[s1_slot_r]  <= acc_new_s;
                    pg_phase          <= acc_new_s[PHASE_W-1:PHASE_W-10];
                    pg_slot           <= s1_slot_r;
                    pg_valid          <= 1'b1;
                    slot_sync         <= (s1_slot_r == 5'd0);
                    pend_r[s1_slot_r] <= 1'b0;
                end else begin
                    pg_valid  <= 1'b0;
                    slot_sync <= 1'b0;
                end
            end else begin
                pg_valid  <= 1'b0;
                slot_sync <= 1'b0;
            end
            // A key-on landing on the slot's own stage-2 edge must survive the clear above
            if (kon && (kon_slot < 5'd24)) begin
                pend_r[kon_slot] <= 1'b1;
            end
        end
    end

endmodule
